micro_run_ctrl: RTL
===================

Name: micro_run_ctrl

Overview:
- Run controller for the `micro` core: loads a program image into IRAM, then sequences the core.
- Sequencing covers reset, the PCenable cadence (continuous run or single-step) and halting.
- Halting is triggered by the halt instruction or an external request.
- Sits between the board/host logic and `micro`; replaces the free-running PCenable generator and manual reset.

Parameters:
WIDTH, 16, instruction/data word width
IRAM_ADDR_BITS, 8, IRAM address width
STEP_DIV, 3, clocks per PCenable pulse in RUN (>=2)
RST_CYCLES, 2, clocks micro_reset is held in RST state (>=1)
HALT_INSTR, 16'hC000, instruction that stops sequencing when current

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start_load  in  1  IDLE/HALT: begin image load (level, sampled per cycle)
start_run  in  1  IDLE/HALT: reset core and run existing image
mode_step  in  1  1 = single-step mode, 0 = continuous run
step_req  in  1  step request; rising edge counts
halt_req  in  1  force HALT
ld_valid  in  1  load word valid
ld_ready  out  1  load word accepted
ld_data  in  WIDTH  load word
ld_last  in  1  final word of image
iram_wa  out  IRAM_ADDR_BITS  IRAM write address
iram_wen  out  1  IRAM write enable
iram_din  out  WIDTH  IRAM write data
micro_reset  out  1  active-high reset to `micro`
pc_enable  out  1  PCenable to `micro`
mon_pc  in  IRAM_ADDR_BITS  current PC from `micro`
mon_instr  in  WIDTH  current instruction from `micro`
state_o  out  3  current FSM state encoding
halted  out  1  state == HALT
load_err  out  1  image overflowed IRAM (sticky until next start_load)
instr_count  out  32  pc_enable pulses issued since last RST

Behaviour:
- Reset values, all outputs registered:
  - state = IDLE, micro_reset = 1, pc_enable = 0, iram_wen = 0
  - iram_wa = 0, iram_din = 0, ld_ready = 0, load_err = 0, instr_count = 0
- Async assert and sync deassert of reset_n; reset mid-load or mid-run aborts to IDLE.
- States:
  - IDLE: micro_reset = 1.
    - start_load -> LOAD, and clears load_err and the write address.
    - Else start_run -> RST.
    - Both asserted: load wins.
  - LOAD: ld_ready = 1, micro_reset = 1.
    - On each ld_valid & ld_ready, the next cycle drives iram_wen = 1, iram_wa = addr, iram_din = ld_data. addr then increments.
    - ld_last accepted -> RST after the final write.
    - Word accepted at addr = 2^IRAM_ADDR_BITS-1 without ld_last: word is written, load_err = 1, -> IDLE. No address wrap.
  - RST: micro_reset = 1 for exactly RST_CYCLES clocks; instr_count cleared on entry.
    - Exit -> STEP if mode_step = 1, else RUN.
  - RUN: micro_reset = 0. Divider counts 0..STEP_DIV-1; pc_enable = 1 for one clock when the divider wraps.
    - First pulse comes STEP_DIV clocks after entry.
  - STEP: micro_reset = 0. Each rising edge of step_req (registered edge detect) issues one pc_enable pulse.
    - The pulse comes 1 clock after the sampled edge.
    - Edges arriving while a pulse is in flight are ignored.
  - HALT: micro_reset = 0, pc_enable = 0, core state preserved.
    - start_load -> LOAD; start_run -> RST.
- Halt instruction: when a pulse is due and mon_instr == HALT_INSTR, the pulse is suppressed and state -> HALT. instr_count is not incremented.
- halt_req in RUN/STEP -> HALT next cycle. It wins over a pulse due in the same cycle.
- mode_step change:
  - RUN -> STEP: immediate, divider cleared.
  - STEP -> RUN: immediate, divider restarts from 0.
- instr_count increments on every issued pc_enable and saturates at 2^32-1.
- pc_enable is never high while micro_reset is high.

Optional Feature:
- MICRO_RUN_CTRL_BKPT_EN: adds inputs bkpt_en (1) and bkpt_addr (IRAM_ADDR_BITS).
  - A due pulse with bkpt_en & mon_pc == bkpt_addr is suppressed and the state -> HALT, same as the halt instruction.
  - start_run from HALT then restarts. A breakpoint match is ignored for the first pulse after RST.
- Without the macro: no ports, no compare logic.

Decomposition:
- Package micro_pkg:
  - state enum IDLE/LOAD/RST/RUN/STEP/HALT (3-bit)
  - HALT_INSTR default constant
  - default WIDTH/IRAM_ADDR_BITS constants
- One sub-module: micro_step_gen, which holds the divider, step_req edge detect and pulse/suppress logic. It takes run/step enables and a stop condition, and emits pc_enable.
- FSM and loader stay in the top.

Test Plan:
- Load 5 words (0x1111..0x5555, ld_last on 5th) with ld_valid toggling -> iram_wen at wa 0..4 with matching data; RST 2 clocks; RUN.
- RUN, STEP_DIV=3, mon_instr never HALT_INSTR for 30 clocks -> pc_enable every 3rd clock, first at clock 3, instr_count = 10.
- mon_instr = 16'hC000 when a pulse is due -> no pulse, halted = 1 next clock, instr_count unchanged.
- mode_step = 1, three step_req edges spaced 5 clocks, plus one edge 1 clock after a step -> exactly 3 pulses.
- 256 words without ld_last -> all 256 written, load_err = 1, state IDLE; next start_load clears load_err.
- reset_n low mid-RUN -> micro_reset = 1 and pc_enable = 0 immediately (async); state IDLE after release. With MICRO_RUN_CTRL_BKPT_EN, bkpt_addr = 8'd7 -> halt with mon_pc = 7.

Source files
------------

// File: rtl/micro_pkg.sv
// Shared types and defaults for the micro core run controller.
package micro_pkg;

  localparam int                WIDTH_DEF          = 16;
  localparam int                IRAM_ADDR_BITS_DEF = 8;
  localparam logic [15:0]       HALT_INSTR_DEF     = 16'hC000;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RST  = 3'd2,
    RUN  = 3'd3,
    STEP = 3'd4,
    HALT = 3'd5
  } state_t;

  // States in which the core is held in reset.
  function automatic logic holds_reset(input state_t s);
    return (s == IDLE) || (s == LOAD) || (s == RST);
  endfunction

endpackage

// File: rtl/micro_step_gen.sv
// PCenable pulse generator: RUN-mode divider, STEP-mode edge detect, and
// suppression of a due pulse on a stop condition or forced halt.
module micro_step_gen
  import micro_pkg::*;
#(
  parameter int STEP_DIV = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run_en,
  input  logic step_en,
  input  logic step_req,
  input  logic stop_cond,
  input  logic force_stop,
  output logic pc_enable,
  output logic fire,
  output logic halt_hit
);

  localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  logic [DIV_W-1:0] div_q;
  logic             step_d1;
  logic             pending;
  logic             div_wrap;
  logic             rise;
  logic             due;

  assign div_wrap = (div_q == DIV_W'(STEP_DIV - 1));
  assign rise     = step_req & ~step_d1;
  assign due      = (run_en & div_wrap) | (step_en & pending);
  assign fire     = due & ~stop_cond & ~force_stop;
  assign halt_hit = due & stop_cond;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q     <= '0;
      step_d1   <= 1'b0;
      pending   <= 1'b0;
      pc_enable <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values;
      // blocking here would let div_q/pending ordering leak into each other.
      step_d1   <= step_req;
      pc_enable <= fire;
      if (!run_en || div_wrap) div_q <= '0;
      else                     div_q <= div_q + DIV_W'(1);
      // A new edge is taken only when no pulse is pending or on the wire.
      if (!step_en || due)                         pending <= 1'b0;
      else if (rise && !pending && !pc_enable)     pending <= 1'b1;
    end
  end

endmodule

// File: rtl/micro_run_ctrl.sv
// Run controller for the micro core: IRAM image loader plus reset/run/step/halt
// sequencing. Defining MICRO_RUN_CTRL_BKPT_EN adds a PC breakpoint compare.
module micro_run_ctrl
  import micro_pkg::*;
#(
  parameter int               WIDTH          = WIDTH_DEF,
  parameter int               IRAM_ADDR_BITS = IRAM_ADDR_BITS_DEF,
  parameter int               STEP_DIV       = 3,
  parameter int               RST_CYCLES     = 2,
  parameter logic [WIDTH-1:0] HALT_INSTR     = WIDTH'(HALT_INSTR_DEF)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start_load,
  input  logic                      start_run,
  input  logic                      mode_step,
  input  logic                      step_req,
  input  logic                      halt_req,
  input  logic                      ld_valid,
  output logic                      ld_ready,
  input  logic [WIDTH-1:0]          ld_data,
  input  logic                      ld_last,
  output logic [IRAM_ADDR_BITS-1:0] iram_wa,
  output logic                      iram_wen,
  output logic [WIDTH-1:0]          iram_din,
  output logic                      micro_reset,
  output logic                      pc_enable,
  input  logic [IRAM_ADDR_BITS-1:0] mon_pc,
  input  logic [WIDTH-1:0]          mon_instr,
  output logic [2:0]                state_o,
  output logic                      halted,
  output logic                      load_err,
`ifdef MICRO_RUN_CTRL_BKPT_EN
  input  logic                      bkpt_en,
  input  logic [IRAM_ADDR_BITS-1:0] bkpt_addr,
`endif
  output logic [31:0]               instr_count
);

  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  logic [1:0]                rst_sync;
  logic                      rst_n;
  state_t                    state, state_nx;
  logic [IRAM_ADDR_BITS-1:0] addr_q;
  logic [RC_W-1:0]           rst_cnt;
  logic                      accept, addr_full, rst_done;
  logic                      load_start, run_start;
  logic                      run_en, step_en, stop_cond, fire, halt_hit;

  // Reset asserts asynchronously but is released two clocks after reset_n rises.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign accept     = ld_valid & ld_ready;
  assign addr_full  = &addr_q;
  assign rst_done   = (rst_cnt == RC_W'(RST_CYCLES - 1));
  assign load_start = (state != LOAD) && (state_nx == LOAD);
  assign run_start  = (state != RST) && (state_nx == RST);
  assign run_en     = (state == RUN) & ~mode_step;
  assign step_en    = (state == STEP) & mode_step;
  assign state_o    = state;

  always_comb begin
    // NOTE: default first so every path assigns state_nx and no latch is inferred.
    state_nx = state;
    unique case (state)
      IDLE, HALT: begin
        if (start_load)     state_nx = LOAD;
        else if (start_run) state_nx = RST;
      end
      LOAD: begin
        if (accept && ld_last)        state_nx = RST;
        else if (accept && addr_full) state_nx = IDLE;
      end
      RST:  if (rst_done) state_nx = mode_step ? STEP : RUN;
      RUN:  if (halt_req || halt_hit) state_nx = HALT;
            else if (mode_step)       state_nx = STEP;
      STEP: if (halt_req || halt_hit) state_nx = HALT;
            else if (!mode_step)      state_nx = RUN;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      micro_reset <= 1'b1;
      ld_ready    <= 1'b0;
      halted      <= 1'b0;
      rst_cnt     <= '0;
    end else begin
      state       <= state_nx;
      micro_reset <= holds_reset(state_nx);
      ld_ready    <= (state_nx == LOAD);
      halted      <= (state_nx == HALT);
      rst_cnt     <= (state == RST) ? rst_cnt + RC_W'(1) : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      iram_wen <= 1'b0;
      iram_wa  <= '0;
      iram_din <= '0;
      load_err <= 1'b0;
    end else begin
      iram_wen <= accept;
      if (load_start) begin
        addr_q   <= '0;
        load_err <= 1'b0;
      end else if (accept) begin
        iram_wa  <= addr_q;
        iram_din <= ld_data;
        // The last IRAM slot is written but the address never wraps.
        if (addr_full) begin
          if (!ld_last) load_err <= 1'b1;
        end else begin
          addr_q <= addr_q + IRAM_ADDR_BITS'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      instr_count <= '0;
    else if (run_start)              instr_count <= '0;
    else if (fire && !(&instr_count)) instr_count <= instr_count + 32'd1;
  end

`ifdef MICRO_RUN_CTRL_BKPT_EN
  // The first pulse after RST never breaks, so a restart can leave bkpt_addr.
  logic first_pulse;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             first_pulse <= 1'b1;
    else if (state == RST)  first_pulse <= 1'b1;
    else if (fire)          first_pulse <= 1'b0;
  end
  assign stop_cond = (mon_instr == HALT_INSTR) |
                     (bkpt_en & (mon_pc == bkpt_addr) & ~first_pulse);
`else
  logic unused_mon_pc;
  assign unused_mon_pc = ^mon_pc;
  assign stop_cond     = (mon_instr == HALT_INSTR);
`endif

  micro_step_gen #(
    .STEP_DIV (STEP_DIV)
  ) u_step_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .run_en     (run_en),
    .step_en    (step_en),
    .step_req   (step_req),
    .stop_cond  (stop_cond),
    .force_stop (halt_req),
    .pc_enable  (pc_enable),
    .fire       (fire),
    .halt_hit   (halt_hit)
  );

endmodule
